// File: rtl/tsp_pkg.sv
// tsp_pkg
// Shared definitions for the transport-stream output scheduler slice:
//   PACK_BYTES - TS packet length in bytes (188)
//   BYTE_W     - width of one TS byte
//   CNT_W      - width of the in-packet byte counter
//   tsp_state_e - scheduler FSM states (IDLE, LOCK)
package tsp_pkg;

  localparam int PACK_BYTES = 188;
  localparam int BYTE_W     = 8;
  localparam int CNT_W      = 8;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } tsp_state_e;

endpackage

// File: rtl/tsp_prio_enc.sv
// tsp_prio_enc
// Combinational highest-index priority encoder used for source arbitration.
// Ports:
//   req_i  [NUM_SRC-1:0] request vector (one bit per source)
//   idx_o  [SEL_W-1:0]   index of the highest set request bit, 0 if none
//   any_o                high when at least one request bit is set
module tsp_prio_enc #(
  parameter int NUM_SRC = 18,
  parameter int SEL_W   = 5
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic [SEL_W-1:0]   idx_o,
  output logic               any_o
);

  // Ascending scan: later (higher) set bits overwrite earlier ones, so the
  // surviving index is the highest one.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req_i[i]) begin
        idx_o = SEL_W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tsp_out_sched.sv
// tsp_out_sched
// Muxes one of NUM_SRC aligned TS byte streams onto a single output, one
// whole packet at a time. Source 0 is the base stream; on each source-0 sync
// the highest-index source claiming the packet (src_matched) wins and stays
// granted until PACK_BYTES valid bytes have passed or an early sync truncates
// the packet. All outputs are registered (1 clk latency).
// Ports:
//   clk, rst_n                    byte clock, synchronous active-low reset
//   src_matched/valid/sync [N]    per-source claim flag, byte valid, packet start
//   src_data [8N]                 per-source byte, source k in [8k+7:8k]
//   out_valid/out_sync/out_data   muxed TS output
//   out_sel                       source granted for the byte on out_*
//   locked                        high while the byte on out_* is part of a packet
//   short_pkt                     one-cycle pulse when a packet was cut short
//   pkt_cnt, err_cnt              completed packets / short packets; only
//                                 present when TSP_OUT_SCHED_STATS_EN is defined
module tsp_out_sched #(
  parameter int NUM_SRC    = 18,
  parameter int PACK_BYTES = tsp_pkg::PACK_BYTES,
  parameter int SEL_W      = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   src_matched,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [NUM_SRC-1:0]   src_sync,
  input  logic [8*NUM_SRC-1:0] src_data,
  output logic                 out_valid,
  output logic                 out_sync,
  output logic [7:0]           out_data,
  output logic [SEL_W-1:0]     out_sel,
  output logic                 locked,
  output logic                 short_pkt
`ifdef TSP_OUT_SCHED_STATS_EN
  ,
  output logic [31:0]          pkt_cnt,
  output logic [15:0]          err_cnt
`endif
);

  import tsp_pkg::*;

  tsp_state_e        state_q, state_d;
  logic [SEL_W-1:0]  grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              seen_q, seen_d;
  logic              out_valid_q, out_valid_d;
  logic              out_sync_q, out_sync_d;
  logic [BYTE_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic              locked_q, locked_d;
  logic              short_q, short_d;

  logic [SEL_W-1:0]  enc_idx, arb_idx, fwd_idx;
  logic              enc_any, fwd_en;
`ifdef TSP_OUT_SCHED_STATS_EN
  logic              pkt_done;
  logic [31:0]       pkt_cnt_q;
  logic [15:0]       err_cnt_q;
`endif

  tsp_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_prio_enc (
    .req_i (src_matched),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  assign arb_idx = enc_any ? enc_idx : '0;

  // Next-state and output selection. fwd_en/fwd_idx pick which source's byte
  // is copied to the output register this cycle. seen_q keeps the output
  // silent after reset until the first source-0 sync, so a packet aborted by
  // reset never leaks its tail onto the output.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    seen_d      = seen_q;
    out_sel_d   = '0;
    locked_d    = 1'b0;
    short_d     = 1'b0;
    fwd_en      = 1'b0;
    fwd_idx     = '0;
`ifdef TSP_OUT_SCHED_STATS_EN
    pkt_done    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (src_valid[0] && src_sync[0]) begin
          state_d   = LOCK;
          grant_d   = arb_idx;
          cnt_d     = CNT_W'(1);
          seen_d    = 1'b1;
          fwd_en    = 1'b1;
          fwd_idx   = arb_idx;
          out_sel_d = arb_idx;
          locked_d  = 1'b1;
        end else if (seen_q) begin
          fwd_en    = 1'b1;
        end
      end
      LOCK: begin
        locked_d  = 1'b1;
        out_sel_d = grant_q;
        fwd_en    = 1'b1;
        fwd_idx   = grant_q;
        if (src_valid[grant_q]) begin
          if (src_sync[grant_q] && (int'(cnt_q) < PACK_BYTES)) begin
            // Early sync: drop the truncated packet and arbitrate the new one.
            short_d   = 1'b1;
            grant_d   = arb_idx;
            cnt_d     = CNT_W'(1);
            fwd_idx   = arb_idx;
            out_sel_d = arb_idx;
          end else begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            if (int'(cnt_q) + 1 >= PACK_BYTES) begin
              state_d = IDLE;
`ifdef TSP_OUT_SCHED_STATS_EN
              pkt_done = 1'b1;
`endif
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = fwd_en && src_valid[fwd_idx];
    out_sync_d  = out_valid_d && src_sync[fwd_idx];
    out_data_d  = out_valid_d ? src_data[int'(fwd_idx)*BYTE_W +: BYTE_W] : out_data_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      cnt_q       <= '0;
      seen_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sync_q  <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      locked_q    <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      out_valid_q <= out_valid_d;
      out_sync_q  <= out_sync_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      locked_q    <= locked_d;
      short_q     <= short_d;
    end
  end

`ifdef TSP_OUT_SCHED_STATS_EN
  // Free-running wrapping statistics counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (pkt_done) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (short_d)  err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

  assign out_valid = out_valid_q;
  assign out_sync  = out_sync_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign locked    = locked_q;
  assign short_pkt = short_q;

endmodule
